pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. It merges per-stage stall requests into the per-register hold vector and bubble vector consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It turns a MEM-stage exception or ERET into a flush pulse plus a PC redirect. The redirect is deferred while an AXI instruction fetch is still outstanding, and a saturating stall-cycle counter is kept for debug.

---
 rtl/cpu_defs.sv | 11 +
 rtl/stall_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared pipeline constants, stall-bit indices and control FSM encoding
`timescale 1ns/1ps
package cpu_defs;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] ERET_CODE  = 32'h0000_000E;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    typedef enum logic [1:0] {IDLE, WAIT_FETCH, REDIRECT} ctrl_state_t;
endpackage

// File: rtl/stall_counter.sv
// stall_counter: 32-bit saturating event counter with synchronous preload
//   clock_i, reset_i : clock, async active-high reset (clears count)
//   en               : count one event this cycle
//   load, load_value : preload the count (wins over en)
//   count            : current value, sticks at all-ones
`timescale 1ns/1ps
module stall_counter (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count
);
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) count <= '0;
        else if (load) count <= load_value;
        else if (en && count != '1) count <= count + 32'd1;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/bubble merge, exception flush and deferred PC redirect
//   clock_i, reset_i        : clock, async active-high reset
//   stallreq_*_i            : per-stage stall requests (if, id, ex, mem)
//   exception_i/_type_i     : MEM-stage exception or ERET, cause code
//   epc_i                   : return address used for ERET
//   fetch_busy_i            : instruction fetch still outstanding on AXI
//   stall_o, bubble_o       : per-register hold and NOP-insert vectors
//   flush_o                 : clear all pipeline registers
//   redirect_valid_o/_pc_o  : one-cycle PC load strobe and target
//   discard_fetch_o         : drop the in-flight fetch response
//   stall_cycles_o          : saturating count of stalled cycles
`timescale 1ns/1ps
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = cpu_defs::EXC_VECTOR,
    parameter logic [31:0] ERET_CODE  = cpu_defs::ERET_CODE
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        exception_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] epc_i,
    input  logic        fetch_busy_i,
    output logic [3:0]  stall_o,
    output logic [3:0]  bubble_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        discard_fetch_o,
    output logic [31:0] stall_cycles_o
);
    cpu_defs::ctrl_state_t state;
    logic [3:0]  stall_raw;
    logic        cnt_load;
    logic [31:0] cnt_load_value;
    // Preload hook of the perf counter, unused in normal operation
    assign cnt_load       = 1'b0;
    assign cnt_load_value = '0;
    always_comb begin
        stall_raw = '0;
        stall_raw[cpu_defs::STALL_EXMEM] = stallreq_mem_i;
        stall_raw[cpu_defs::STALL_IDEX]  = stallreq_mem_i | stallreq_ex_i;
        stall_raw[cpu_defs::STALL_IFID]  = stallreq_mem_i | stallreq_ex_i | stallreq_id_i;
        // PC is frozen while the stale fetch drains, so no new fetch is issued
        stall_raw[cpu_defs::STALL_PC]    = stallreq_mem_i | stallreq_ex_i | stallreq_id_i
                                         | stallreq_if_i | (state == cpu_defs::WAIT_FETCH);
        stall_o  = reset_i ? 4'b0000 : stall_raw;
        bubble_o = {stall_o[3], stall_o[2] & ~stall_o[3], stall_o[1] & ~stall_o[2], stall_o[0] & ~stall_o[1]};
        flush_o  = ~reset_i & exception_i & (state == cpu_defs::IDLE);
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= cpu_defs::IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            discard_fetch_o  <= 1'b0;
        end else begin
            case (state)
                cpu_defs::IDLE: if (exception_i) begin
                    redirect_pc_o    <= (exception_type_i == ERET_CODE) ? epc_i : EXC_VECTOR;
                    state            <= fetch_busy_i ? cpu_defs::WAIT_FETCH : cpu_defs::REDIRECT;
                    redirect_valid_o <= ~fetch_busy_i;
                    discard_fetch_o  <= fetch_busy_i;
                end
                cpu_defs::WAIT_FETCH: if (!fetch_busy_i) begin
                    state            <= cpu_defs::REDIRECT;
                    redirect_valid_o <= 1'b1;
                    discard_fetch_o  <= 1'b0;
                end
                cpu_defs::REDIRECT: begin
                    state            <= cpu_defs::IDLE;
                    redirect_valid_o <= 1'b0;
                end
                default: state <= cpu_defs::IDLE;
            endcase
        end
    end
    stall_counter u_cnt (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .en         (|stall_o),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .count      (stall_cycles_o)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl
`timescale 1ns/1ps
module tb_pipeline_ctrl;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stallreq_if_i = 1'b0, stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0, stallreq_mem_i = 1'b0;
    logic        exception_i = 1'b0;
    logic [31:0] exception_type_i = '0;
    logic [31:0] epc_i = 32'h1111_0000;
    logic        fetch_busy_i = 1'b0;
    logic [3:0]  stall_o, bubble_o;
    logic        flush_o, redirect_valid_o, discard_fetch_o;
    logic [31:0] redirect_pc_o, stall_cycles_o;

    typedef struct {
        logic [3:0]  stall;
        logic [3:0]  bubble;
        logic        flush;
        logic        disc;
        logic        rv;
        logic [31:0] cnt;
    } vec_t;
    typedef struct {
        logic [31:0] pc;
        int          due;
    } redir_t;

    vec_t        vq[$];
    redir_t      rq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_no = 0;
    logic [31:0] exp_cnt = '0;

    pipeline_ctrl dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .stallreq_if_i    (stallreq_if_i),
        .stallreq_id_i    (stallreq_id_i),
        .stallreq_ex_i    (stallreq_ex_i),
        .stallreq_mem_i   (stallreq_mem_i),
        .exception_i      (exception_i),
        .exception_type_i (exception_type_i),
        .epc_i            (epc_i),
        .fetch_busy_i     (fetch_busy_i),
        .stall_o          (stall_o),
        .bubble_o         (bubble_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .discard_fetch_o  (discard_fetch_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc_no <= cyc_no + 1;

    always @(posedge clock_i)
        if (!reset_i && exception_i)
            assert (!(redirect_valid_o || discard_fetch_o)) else $error("exception_i raised outside IDLE");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc_no, act, exp);
        end
    endtask

    // Monitor: one expected vector per driven cycle, one redirect entry per pulse
    always @(negedge clock_i) begin
        vec_t   v;
        redir_t r;
        if (vq.size() > 0) begin
            v = vq.pop_front();
            chk("stall_o", {28'd0, stall_o}, {28'd0, v.stall});
            chk("bubble_o", {28'd0, bubble_o}, {28'd0, v.bubble});
            chk("flush_o", {31'd0, flush_o}, {31'd0, v.flush});
            chk("discard_fetch_o", {31'd0, discard_fetch_o}, {31'd0, v.disc});
            chk("redirect_valid_o", {31'd0, redirect_valid_o}, {31'd0, v.rv});
            chk("stall_cycles_o", stall_cycles_o, v.cnt);
        end
        if (redirect_valid_o) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_redirect at cycle %0d: got pc %h want none", cyc_no, redirect_pc_o);
            end else begin
                r = rq.pop_front();
                chk("redirect_pc_o", redirect_pc_o, r.pc);
                chk("redirect_cycle", cyc_no, r.due);
            end
        end
    end

    // req = {mem, ex, id, if}; returns 1 time unit after the next rising edge
    task automatic cyc(input logic [3:0] req, input logic exc, input logic [31:0] typ, input logic busy,
                       input logic [3:0] st, input logic [3:0] bu, input logic fl, input logic dc, input logic rv);
        {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
        exception_i      = exc;
        exception_type_i = typ;
        fetch_busy_i     = busy;
        vq.push_back('{st, bu, fl, dc, rv, exp_cnt});
        @(posedge clock_i);
        if (st != 4'd0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock_i);
        #1;
        chk("reset_stall", {28'd0, stall_o}, 32'd0);
        chk("reset_flush", {31'd0, flush_o}, 32'd0);
        chk("reset_redirect_pc", redirect_pc_o, 32'd0);
        chk("reset_cnt", stall_cycles_o, 32'd0);
        reset_i = 1'b0;
        repeat (10) cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        repeat (3) cyc(4'b0100, 0, 0, 0, 4'b0111, 4'b0100, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        chk("cnt_after_ex", stall_cycles_o, 32'd3);
        cyc(4'b1010, 0, 0, 0, 4'b1111, 4'b1000, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 0);
        cyc(4'b0010, 0, 0, 0, 4'b0011, 4'b0010, 0, 0, 0);
        cyc(4'b1000, 0, 0, 0, 4'b1111, 4'b1000, 0, 0, 0);
        // Plain exception, fetch idle, with a concurrent MEM stall
        rq.push_back('{32'hBFC0_0380, cyc_no + 1});
        cyc(4'b1000, 1, 32'h4, 0, 4'b1111, 4'b1000, 1, 0, 0);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // ERET with fetch busy for five cycles starting at the exception cycle
        epc_i = 32'hBFC0_1234;
        rq.push_back('{32'hBFC0_1234, cyc_no + 6});
        cyc(4'b0000, 1, 32'h0000_000E, 1, 4'b0000, 4'b0000, 1, 0, 0);
        repeat (4) cyc(4'b0000, 0, 0, 1, 4'b0001, 4'b0001, 0, 1, 0);
        cyc(4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0, 1, 0);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        chk("redirect_pc_hold", redirect_pc_o, 32'hBFC0_1234);
        // Reset while waiting on the fetch: no redirect may follow
        epc_i = 32'h2222_0000;
        cyc(4'b0000, 1, 32'h4, 1, 4'b0000, 4'b0000, 1, 0, 0);
        cyc(4'b0000, 0, 0, 1, 4'b0001, 4'b0001, 0, 1, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("async_reset_stall", {28'd0, stall_o}, 32'd0);
        chk("async_reset_bubble", {28'd0, bubble_o}, 32'd0);
        chk("async_reset_discard", {31'd0, discard_fetch_o}, 32'd0);
        chk("async_reset_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
        chk("async_reset_redirect_pc", redirect_pc_o, 32'd0);
        chk("async_reset_cnt", stall_cycles_o, 32'd0);
        exp_cnt = '0;
        @(posedge clock_i);
        #1;
        fetch_busy_i = 1'b0;
        reset_i = 1'b0;
        repeat (4) cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // Saturation: preload near the top through the counter's load hook
        force dut.cnt_load = 1'b1;
        force dut.cnt_load_value = 32'hFFFF_FFFD;
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        release dut.cnt_load;
        release dut.cnt_load_value;
        exp_cnt = 32'hFFFF_FFFD;
        repeat (4) cyc(4'b0100, 0, 0, 0, 4'b0111, 4'b0100, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        chk("cnt_saturated", stall_cycles_o, 32'hFFFF_FFFF);
        @(negedge clock_i);
        #1;
        chk("redirect_queue_drained", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
